// File: rtl/pipe_pkg.sv
// Shared types and constants for the micropipeline sink.
// Define PIPE_SINK_SYNC3_EN to select a three-flop req_in synchroniser.
package pipe_pkg;

  localparam int PIPE_DATA_W = 3;

`ifdef PIPE_SINK_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } sink_state_t;

endpackage

// File: rtl/sync_bit.sv
// N-flop single-bit synchroniser; all flops clear to 0 on synchronous reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pipe_sink_sync.sv
// Clocked tail of the micropipeline: 4-phase req/ack receiver feeding a valid/ready FIFO.
// Synchroniser depth follows PIPE_SINK_SYNC3_EN (see pipe_pkg).
module pipe_sink_sync
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_in,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       ack_out,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic              req_s;
  sink_state_t       state_q, state_d;
  logic              push, pop, full;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_in),
    .q   (req_s)
  );

  // Full is judged on the registered level, so a same-cycle pop never makes room.
  assign full    = (level == LVL_W'(DEPTH));
  assign m_valid = (level != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = mem[rd_ptr];
  assign ack_out = (state_q == ACK);

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (req_s && !full) begin
        push    = 1'b1;
        state_d = ACK;
      end
      ACK: if (!req_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Leaving ACK only on req_s low guarantees one capture per handshake.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: storage has no reset; contents are unobservable while level is 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_sink_sync.sv
// Directed self-checking bench for pipe_sink_sync: handshake latency, FIFO full/wrap, reset mid-handshake.
module tb_pipe_sink_sync;
  import pipe_pkg::*;

  localparam int DW    = 3;
  localparam int DEPTH = 4;
  localparam int N     = SYNC_STAGES;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_in;
  logic [DW-1:0] data_in;
  logic          ack_out;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [2:0]    level;

  int checks = 0;
  int errors = 0;

  pipe_sink_sync #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_in  (req_in),
    .data_in (data_in),
    .ack_out (ack_out),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .level   (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [2:0]    exp_level;
  } burst_vec_t;

  burst_vec_t    burst [4];
  logic [DW-1:0] drain_exp [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bounded wait for ack_out to reach val; expiry shows up as a failed check.
  task automatic wait_ack(input logic val, input string name);
    for (int i = 0; i < 40 && ack_out !== val; i++) tick();
    check(name, ack_out, val);
  endtask

  task automatic handshake(input logic [DW-1:0] d);
    data_in = d;
    req_in  = 1'b1;
    wait_ack(1'b1, "hs_ack_rise");
    req_in  = 1'b0;
    wait_ack(1'b0, "hs_ack_fall");
  endtask

  task automatic pop_one(input logic [DW-1:0] exp, input string name);
    check({name, "_valid"}, m_valid, 1'b1);
    check({name, "_data"}, m_data, exp);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    burst[0] = '{3'd1, 3'd1};
    burst[1] = '{3'd2, 3'd2};
    burst[2] = '{3'd3, 3'd3};
    burst[3] = '{3'd4, 3'd4};
    drain_exp[0] = 3'd2;
    drain_exp[1] = 3'd3;
    drain_exp[2] = 3'd4;
    drain_exp[3] = 3'd5;

    rst = 1'b1; req_in = 1'b0; data_in = '0; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_ack", ack_out, 1'b0);
    check("rst_valid", m_valid, 1'b0);
    check("rst_level", level, 3'd0);

    // Single token: exact edge counts for both handshake phases.
    data_in = 3'b101;
    req_in  = 1'b1;
    for (int i = 0; i < N; i++) tick();
    check("single_ack_early", ack_out, 1'b0);
    tick();
    check("single_ack_rise", ack_out, 1'b1);
    tick();
    check("single_valid", m_valid, 1'b1);
    check("single_data", m_data, 3'b101);
    req_in = 1'b0;
    for (int i = 0; i < N; i++) tick();
    check("single_ack_hold", ack_out, 1'b1);
    tick();
    check("single_ack_fall", ack_out, 1'b0);
    pop_one(3'b101, "single_pop");
    check("single_level0", level, 3'd0);

    // Burst to full with the consumer stalled.
    for (int i = 0; i < 4; i++) begin
      handshake(burst[i].data);
      check("burst_level", level, burst[i].exp_level);
    end
    data_in = 3'd5;
    req_in  = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("full_no_ack", ack_out, 1'b0);
    check("full_level", level, 3'd4);
    pop_one(3'd1, "full_pop1");
    wait_ack(1'b1, "full_late_ack");
    check("full_refill", level, 3'd4);
    req_in = 1'b0;
    wait_ack(1'b0, "full_late_fall");
    for (int i = 0; i < 4; i++) pop_one(drain_exp[i], "drain");
    check("drain_level", level, 3'd0);

    // Push and pop on the same edge at level 2, with the write pointer wrapping.
    handshake(3'd6);
    handshake(3'd7);
    check("pp_pre_level", level, 3'd2);
    data_in = 3'd3;
    req_in  = 1'b1;
    for (int i = 0; i < N; i++) tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("pp_ack", ack_out, 1'b1);
    check("pp_level", level, 3'd2);
    req_in = 1'b0;
    wait_ack(1'b0, "pp_fall");
    pop_one(3'd7, "pp_drain0");
    pop_one(3'd3, "pp_drain1");
    check("pp_empty", level, 3'd0);

    // Pops requested on an empty FIFO are ignored.
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("empty_valid", m_valid, 1'b0);
      check("empty_level", level, 3'd0);
    end
    m_ready = 1'b0;
    handshake(3'd4);
    pop_one(3'd4, "empty_after");

    // Reset while in ACK with req_in still asserted.
    data_in = 3'd2;
    req_in  = 1'b1;
    wait_ack(1'b1, "rstmid_ack");
    rst = 1'b1;
    tick();
    check("rstmid_ack0", ack_out, 1'b0);
    check("rstmid_level0", level, 3'd0);
    rst = 1'b0;
    wait_ack(1'b1, "rstmid_recapture");
    for (int i = 0; i < 10; i++) tick();
    check("rstmid_once", level, 3'd1);
    req_in = 1'b0;
    wait_ack(1'b0, "rstmid_fall");
    check("rstmid_level1", level, 3'd1);
    pop_one(3'd2, "rstmid_pop");

    // Long request: exactly one push.
    data_in = 3'd1;
    req_in  = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    check("long_level", level, 3'd1);
    req_in = 1'b0;
    wait_ack(1'b0, "long_fall");
    check("long_level_after", level, 3'd1);
    pop_one(3'd1, "long_pop");
    check("long_empty", level, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
